// File: rtl/adder_result_capture.sv
// Capture sink for the adder/subtractor vector stream. It checks each beat
// against an internal golden add/subtract and logs the beat into a readable buffer.
module adder_result_capture #(
  parameter  int WIDTH  = 1,
  parameter  int DEPTH  = 8,
  parameter  int ADDR_W = 3,
  localparam int REC_W  = 3*WIDTH+2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [ADDR_W:0]   i_num_vectors,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic              i_cin,
  input  logic [WIDTH-1:0]  i_x,
  input  logic              i_y,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_vec_count,
  output logic [ADDR_W:0]   o_err_count,
  output logic [ADDR_W-1:0] o_first_err,
  output logic              o_err_flag,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [REC_W-1:0]  o_rd_data
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  logic                r_mode;
  logic [ADDR_W:0]     r_limit;
  logic [ADDR_W:0]     r_vec_count;
  logic [ADDR_W:0]     r_err_count;
  logic [ADDR_W-1:0]   r_first_err;
  logic                r_err_flag;
  logic [REC_W-1:0]    r_mem [DEPTH];
  logic [REC_W-1:0]    r_rd_data;

  logic [WIDTH:0]      w_add;
  logic [WIDTH-1:0]    w_sub;
  logic [WIDTH:0]      w_b_cin;
  logic [WIDTH-1:0]    w_x_exp;
  logic                w_y_exp;
  logic                w_mismatch;
  logic                w_accept;
  logic [ADDR_W:0]     w_limit_clip;
  logic [ADDR_W:0]     w_vec_next;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [REC_W-1:0]    w_record;

  // Golden model: subtract borrow-out is a < b + cin in WIDTH+1 bits.
  assign w_add      = {1'b0, i_a} + {1'b0, i_b} + (WIDTH+1)'(i_cin);
  assign w_sub      = i_a - i_b - WIDTH'(i_cin);
  assign w_b_cin    = {1'b0, i_b} + (WIDTH+1)'(i_cin);
  assign w_x_exp    = r_mode ? w_sub : w_add[WIDTH-1:0];
  assign w_y_exp    = r_mode ? ({1'b0, i_a} < w_b_cin) : w_add[WIDTH];
  assign w_mismatch = (i_x != w_x_exp) || (i_y != w_y_exp);

  assign w_accept     = i_in_valid && (r_state == CAPTURE);
  assign w_limit_clip = (i_num_vectors > LP_DEPTH) ? LP_DEPTH : i_num_vectors;
  assign w_vec_next   = r_vec_count + (ADDR_W+1)'(1);
  assign w_wr_addr    = r_vec_count[ADDR_W-1:0];
  assign w_record     = {i_a, i_b, i_cin, i_x, i_y};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_limit     <= '0;
      r_vec_count <= '0;
      r_err_count <= '0;
      r_first_err <= '0;
      r_err_flag  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_mode      <= i_mode;
            r_limit     <= w_limit_clip;
            r_vec_count <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_err_flag  <= 1'b0;
            r_state     <= (w_limit_clip == '0) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (w_accept) begin
            r_vec_count <= w_vec_next;
            if (w_mismatch) begin
              if (r_err_count != '1) r_err_count <= r_err_count + (ADDR_W+1)'(1);
              if (!r_err_flag) begin
                r_err_flag  <= 1'b1;
                r_first_err <= w_wr_addr;
              end
            end
            if (w_vec_next == r_limit) r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Record buffer is never cleared; only accepted beats overwrite it.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_mem[w_wr_addr] <= w_record;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_data <= '0;
    else       r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_in_ready  = (r_state == CAPTURE);
  assign o_busy      = (r_state == CAPTURE);
  assign o_done      = (r_state == DONE);
  assign o_vec_count = r_vec_count;
  assign o_err_count = r_err_count;
  assign o_first_err = r_first_err;
  assign o_err_flag  = r_err_flag;
  assign o_rd_data   = r_rd_data;

endmodule
